// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: FSM states, trap causes and the opcodes
// that steer next-PC selection.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_TRAP = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
  localparam logic [1:0] CAUSE_RANGE      = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd3;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Bit position of the b-type flag in the one-hot {j,u,b,s,i,r} decode.
  localparam int ITYPE_B = 3;

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC target selection and fault classification for the
// instruction currently at the fetch address.
module next_pc_sel
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 16
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [5:0]  instruction_type_i,
  input  logic [6:0]  opcode_i,
  input  logic [31:0] i_imm_i,
  input  logic [31:0] b_imm_i,
  input  logic [31:0] j_imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic        branch_cond_i,
  output logic [31:0] next_pc_o,
  output logic        fault_o,
  output logic [1:0]  cause_o
);

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (opcode_i == OP_JAL) begin
      next_pc_o = pc_i + j_imm_i;
    end else if (opcode_i == OP_JALR) begin
      next_pc_o = (rs1_data_i + i_imm_i) & ~32'h1;
    end else if (instruction_type_i[ITYPE_B] && branch_cond_i) begin
      next_pc_o = pc_i + b_imm_i;
    end
  end

  // Illegal decode outranks any property of the computed target.
  always_comb begin
    cause_o = CAUSE_NONE;
    if (instruction_type_i == 6'b000000) begin
      cause_o = CAUSE_ILLEGAL;
    end else if (next_pc_o[1:0] != 2'b00) begin
      cause_o = CAUSE_MISALIGNED;
    end else if ({2'b00, next_pc_o[31:2]} >= IMEM_WORDS) begin
      cause_o = CAUSE_RANGE;
    end
  end

  assign fault_o = (cause_o != CAUSE_NONE);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, run/step/halt/trap control and retire counter for the single-cycle core.
//   state   | meaning
//   HALT    | stopped, pc held, waiting for run or step
//   RUN     | free-running, one instruction per cycle while run is held
//   STEP    | executing exactly one instruction, then back to HALT
//   TRAP    | faulted; pc/trap_pc/trap_cause frozen until reset
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        la_instruction_write,
  input  logic [5:0]  instruction_type,
  input  logic [6:0]  opcode,
  input  logic [31:0] i_type_immediate,
  input  logic [31:0] b_type_immediate,
  input  logic [31:0] j_type_immediate,
  input  logic [31:0] rs1_data,
  input  logic        branch_cond,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        commit,
  output logic [1:0]  state,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] retired_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic [31:0] retired_q;
  logic [31:0] next_pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        exec;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_sel #(.IMEM_WORDS(IMEM_WORDS)) u_next_pc_sel (
    .pc_i               (pc_q),
    .pc_plus4_i         (pc_plus4),
    .instruction_type_i (instruction_type),
    .opcode_i           (opcode),
    .i_imm_i            (i_type_immediate),
    .b_imm_i            (b_type_immediate),
    .j_imm_i            (j_type_immediate),
    .rs1_data_i         (rs1_data),
    .branch_cond_i      (branch_cond),
    .next_pc_o          (next_pc),
    .fault_o            (fault),
    .cause_o            (fault_cause)
  );

  always_comb begin
    exec         = ((state_q == ST_RUN) && run && !la_instruction_write) || (state_q == ST_STEP);
    commit       = exec && !fault;
    state_d      = state_q;
    pc_d         = pc_q;
    trap_pc_d    = trap_pc_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      ST_HALT: begin
        if (!la_instruction_write) begin
          if (run)       state_d = ST_RUN;
          else if (step) state_d = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        if (!exec) begin
          state_d = ST_HALT;
        end else if (fault) begin
          state_d      = ST_TRAP;
          trap_pc_d    = pc_q;
          trap_cause_d = fault_cause;
        end else begin
          pc_d = next_pc;
          if ((state_q == ST_STEP) || (opcode == OP_SYSTEM)) state_d = ST_HALT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_HALT;
      pc_q         <= RESET_PC;
      trap_pc_q    <= 32'h0;
      trap_cause_q <= CAUSE_NONE;
      retired_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      trap_pc_q    <= trap_pc_d;
      trap_cause_q <= trap_cause_d;
      if (commit) retired_q <= retired_q + 32'd1;
    end
  end

  assign pc            = pc_q;
  assign state         = state_q;
  assign trap_cause    = trap_cause_q;
  assign trap_pc       = trap_pc_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed walk through the main scenarios, then random
// decode/control traffic compared each cycle against a behavioural model.
module tb_fetch_pc_unit;

  localparam int unsigned IMEM = 16;

  logic        clk = 1'b0;
  logic        rst_n, run, step, la_instruction_write, branch_cond;
  logic [5:0]  instruction_type;
  logic [6:0]  opcode;
  logic [31:0] i_type_immediate, b_type_immediate, j_type_immediate, rs1_data;
  logic [31:0] pc, pc_plus4, trap_pc, retired_count;
  logic        commit;
  logic [1:0]  state, trap_cause;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 halt, 1 run, 2 step, 3 trap
  int          m_state;
  logic [31:0] m_pc, m_tpc, m_ret;
  logic [1:0]  m_cause;

  fetch_pc_unit #(.IMEM_WORDS(IMEM), .RESET_PC(32'h0)) dut (
    .clk, .rst_n, .run, .step, .la_instruction_write,
    .instruction_type, .opcode, .i_type_immediate, .b_type_immediate,
    .j_type_immediate, .rs1_data, .branch_cond,
    .pc, .pc_plus4, .commit, .state, .trap_cause, .trap_pc, .retired_count
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_target();
    if (opcode == 7'b1101111) return m_pc + j_type_immediate;
    if (opcode == 7'b1100111) return (rs1_data + i_type_immediate) & 32'hFFFF_FFFE;
    if (instruction_type[3] && branch_cond) return m_pc + b_type_immediate;
    return m_pc + 32'd4;
  endfunction

  function automatic logic [1:0] m_fault(input logic [31:0] t);
    if (instruction_type == 6'd0) return 2'd3;
    if ((t % 4) != 0) return 2'd1;
    if ((t / 4) >= IMEM) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_exec();
    return (m_state == 1 && run && !la_instruction_write) || m_state == 2;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = 32'h0; m_tpc = 32'h0; m_ret = 32'h0; m_cause = 2'd0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    logic [1:0]  c;
    t = m_target();
    c = m_fault(t);
    if (rst_n) begin
      model_reset();
    end else if (m_state == 0) begin
      if (!la_instruction_write && run)       m_state = 1;
      else if (!la_instruction_write && step) m_state = 2;
    end else if (m_state != 3) begin
      if (!m_exec()) begin
        m_state = 0;
      end else if (c != 2'd0) begin
        m_state = 3; m_tpc = m_pc; m_cause = c;
      end else begin
        m_ret = m_ret + 1;
        m_pc  = t;
        if (m_state == 2 || opcode == 7'b1110011) m_state = 0;
      end
    end
  endtask

  // Inputs are already applied; compare everything mid-cycle, then clock both sides.
  task automatic tick();
    logic [1:0] c;
    @(negedge clk);
    c = m_fault(m_target());
    chk("pc",       pc,            m_pc);
    chk("pc_plus4", pc_plus4,      m_pc + 32'd4);
    chk("state",    {30'd0, state}, m_state);
    chk("commit",   {31'd0, commit}, {31'd0, m_exec() && c == 2'd0});
    chk("tcause",   {30'd0, trap_cause}, {30'd0, m_cause});
    chk("trap_pc",  trap_pc,       m_tpc);
    chk("retired",  retired_count, m_ret);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_instr(input logic [5:0] ty, input logic [6:0] op);
    instruction_type = ty; opcode = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; tick(); rst_n = 1'b0;
  endtask

  task automatic rand_inputs();
    int k;
    k = $urandom_range(0, 9);
    run  = ($urandom_range(0, 7) != 0);
    step = ($urandom_range(0, 3) == 0);
    la_instruction_write = ($urandom_range(0, 15) == 0);
    branch_cond = $urandom_range(0, 1);
    i_type_immediate = $urandom; b_type_immediate = $urandom;
    j_type_immediate = $urandom; rs1_data = $urandom;
    case (k)
      0, 1, 2, 3: set_instr(6'b000010, 7'b0010011);
      4, 5: begin
        set_instr(6'b001000, 7'b1100011);
        b_type_immediate = 32'($urandom_range(0, 17) * 4) - m_pc + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      end
      6: begin
        set_instr(6'b100000, 7'b1101111);
        j_type_immediate = 32'($urandom_range(0, 17) * 4) - m_pc + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      end
      7: begin
        set_instr(6'b000010, 7'b1100111);
        rs1_data = 32'($urandom_range(0, 20) * 4);
        i_type_immediate = 32'($urandom_range(0, 40)) - 32'd20;
      end
      8: set_instr(6'b000010, 7'b1110011);
      default: begin
        if ($urandom_range(0, 2) == 0) set_instr(6'b000000, 7'($urandom));
        else set_instr(6'(1 << $urandom_range(0, 5)), 7'b0110011);
      end
    endcase
    rst_n = (m_state == 3 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0; step = 1'b0; la_instruction_write = 1'b0;
    branch_cond = 1'b0; set_instr(6'b000010, 7'b0010011);
    i_type_immediate = 32'd0; b_type_immediate = 32'd0;
    j_type_immediate = 32'd0; rs1_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b0;

    // sequential run: HALT->RUN, then three addi retire
    run = 1'b1;
    repeat (4) tick();
    chk("seq_pc", pc, 32'd12);
    chk("seq_retired", retired_count, 32'd3);
    // taken branch from 12 by +16
    set_instr(6'b001000, 7'b1100011); b_type_immediate = 32'd16; branch_cond = 1'b1;
    tick();
    chk("branch_pc", pc, 32'd28);
    // jalr to 40-16, then jalr to out-of-range
    set_instr(6'b000010, 7'b1100111); rs1_data = 32'd40; i_type_immediate = -32'sd16;
    tick();
    chk("jalr_pc", pc, 32'd24);
    chk("jalr_link", pc_plus4, 32'd28);
    rs1_data = 32'd0;
    tick();
    chk("range_state", {30'd0, state}, 32'd3);
    chk("range_cause", {30'd0, trap_cause}, 32'd2);
    chk("range_tpc", trap_pc, 32'd24);
    step = 1'b1; tick(); step = 1'b0;
    chk("trap_hold_pc", pc, 32'd24);
    do_reset();

    // jal forward, back, then misaligned
    set_instr(6'b100000, 7'b1101111); j_type_immediate = 32'd60;
    repeat (2) tick();
    chk("jal_fwd", pc, 32'd60);
    j_type_immediate = -32'sd60; tick();
    chk("jal_back", pc, 32'd0);
    j_type_immediate = 32'd2; tick();
    chk("mis_cause", {30'd0, trap_cause}, 32'd1);
    do_reset();

    // single step, then run+step together
    run = 1'b0; step = 1'b1; set_instr(6'b000010, 7'b0010011);
    tick(); step = 1'b0;
    chk("step_state", {30'd0, state}, 32'd2);
    tick();
    chk("step_pc", pc, 32'd4);
    chk("step_halt", {30'd0, state}, 32'd0);
    chk("step_ret", retired_count, 32'd1);
    run = 1'b1; step = 1'b1; tick(); step = 1'b0;
    chk("run_wins", {30'd0, state}, 32'd1);
    // loader stop, then illegal decode, then reset out of trap
    la_instruction_write = 1'b1; tick();
    chk("la_halt", {30'd0, state}, 32'd0);
    chk("la_pc", pc, 32'd4);
    la_instruction_write = 1'b0; tick();
    set_instr(6'b000000, 7'b0010011); tick();
    chk("ill_cause", {30'd0, trap_cause}, 32'd3);
    chk("ill_tpc", trap_pc, 32'd4);
    do_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_ret", retired_count, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter and fetch-control stage directly upstream of the instruction memory. It drives the fetch address and selects the next PC from the decoded instruction fields: sequential, branch, jal or jalr. A run/step/halt/trap state machine generates the per-cycle commit strobe that gates architectural writes in the rest of the single-cycle core. Control and debug come from the logic-analyser interface.

Parameters:
IMEM_WORDS, 16, instruction-memory depth in 32-bit words; targets at or beyond this depth trap.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-high reset (1 = reset); name kept for codebase consistency.
run  input  1  level; 1 = free-run requested.
step  input  1  single-cycle pulse; requests execution of exactly one instruction from HALT.
la_instruction_write  input  1  instruction loading active; forces a stop.
instruction_type  input  6  one-hot {j,u,b,s,i,r} from decode.
opcode  input  7  instruction[6:0].
i_type_immediate  input  32  sign-extended I-type immediate.
b_type_immediate  input  32  sign-extended B-type immediate.
j_type_immediate  input  32  sign-extended J-type immediate.
rs1_data  input  32  register-file read of rs1, used for jalr.
branch_cond  input  1  comparator result for the current branch.
pc  output  32  fetch address to instruction memory.
pc_plus4  output  32  pc+4; link value for jal/jalr.
commit  output  1  current instruction retires this cycle; gates register-file and memory writes.
state  output  2  0 HALT, 1 RUN, 2 STEP, 3 TRAP.
trap_cause  output  2  0 none, 1 misaligned target, 2 out-of-range target, 3 illegal instruction.
trap_pc  output  32  PC of the faulting instruction.
retired_count  output  32  count of committed instructions.

Behaviour:
- Reset (rst_n=1 at edge): state=HALT, pc=RESET_PC, trap_cause=0, trap_pc=0, retired_count=0. commit is combinational and 0 in HALT.
- Next-PC selection, combinational; all arithmetic is 32-bit mod 2^32:
  - opcode 1101111 (jal): pc + j_type_immediate.
  - opcode 1100111 (jalr): (rs1_data + i_type_immediate) & ~32'h1.
  - b_type and branch_cond: pc + b_type_immediate.
  - Otherwise: pc_plus4.
- Fault detection on the current instruction, highest priority first:
  - Illegal: instruction_type == 0.
  - Misaligned: next_pc[1:0] != 0.
  - Out of range: next_pc[31:2] >= IMEM_WORDS.
- exec = (state==RUN and run and !la_instruction_write) or state==STEP.
- commit = exec and no fault.
- HALT:
  - run=1 and !la_instruction_write -> RUN.
  - Else step=1 and !la_instruction_write -> STEP.
  - pc holds.
- RUN:
  - If exec and no fault: pc<=next_pc.
  - If exec and fault: -> TRAP; pc holds; trap_pc<=pc; trap_cause latched.
  - run=0 or la_instruction_write=1 -> HALT with no commit that cycle.
  - opcode 1110011 (ecall/ebreak) commits, pc<=pc+4, then -> HALT.
- STEP: execute one instruction exactly as in RUN, then -> HALT, or -> TRAP on fault.
- TRAP:
  - commit=0; pc, trap_pc and trap_cause hold.
  - Exit only through reset; run, step and la_instruction_write are ignored.
- retired_count increments by 1 on each commit and wraps from 32'hFFFF_FFFF to 0.
- Simultaneous run and step in HALT: run wins.
- step asserted outside HALT is ignored.
- Reset has priority over every other input in every state, including mid-STEP.

Decomposition:
- Shared package: state encodings (ST_HALT, ST_RUN, ST_STEP, ST_TRAP), trap-cause constants, and opcode constants (OP_JAL, OP_JALR, OP_BRANCH, OP_SYSTEM).
- One sub-module: next_pc_sel, the combinational target computation and fault detection. The FSM and counters stay in the top level.

Test Plan:
1. Reset, then run=1 with addi-type decode (i_type, opcode 0010011) for 3 cycles -> pc steps 0, 4, 8, 12; commit=1 each cycle; retired_count=3.
2. pc=12, b_type, branch_cond=1, b_imm=16 -> next pc=28. Same instruction with branch_cond=0 -> pc=16.
3. pc=24, jalr, rs1_data=40, i_imm=-16 -> pc=24, pc_plus4=28. Then rs1_data=0 -> TRAP, cause=2, trap_pc=24, commit=0, pc stays 24.
4. pc=60, jal, j_imm=-60 -> pc=0. Then jal with j_imm=2 -> TRAP, cause=1.
5. From HALT, step pulse -> exactly one commit, state goes STEP then HALT, pc advances by 4. step+run in the same cycle -> RUN.
6. In RUN, assert la_instruction_write -> HALT, commit=0, pc frozen. instruction_type=0 in RUN -> TRAP, cause=3. Reset mid-TRAP -> HALT, pc=0, counters cleared.
